// File: rtl/retire_trace_unit.sv
// rtl/retire_trace_unit.sv - retirement trace producer: classifies retiring instructions and queues numbered records
// A drop happens only when full with no pop in the same cycle; the pop frees the slot.
module retire_trace_unit #(
  parameter int DEPTH  = 4,
  parameter int INUM_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic [15:0]       wb_pc,
  input  logic [15:0]       wb_inst,
  input  logic              wb_reg_write,
  input  logic [2:0]        wb_reg_sel,
  input  logic [15:0]       wb_reg_data,
  input  logic              wb_mem_read,
  input  logic              wb_mem_write,
  input  logic [15:0]       wb_mem_addr,
  input  logic [15:0]       wb_mem_data,
  input  logic              wb_halt,
  output logic              wb_stall,
  output logic              tr_valid,
  input  logic              tr_ready,
  output logic [2:0]        tr_kind,
  output logic [INUM_W-1:0] tr_inum,
  output logic [INUM_W-1:0] tr_cycle,
  output logic [15:0]       tr_pc,
  output logic [15:0]       tr_inst,
  output logic [2:0]        tr_reg,
  output logic [15:0]       tr_reg_data,
  output logic [15:0]       tr_addr,
  output logic [15:0]       tr_mem_data,
  output logic              halted,
  output logic              overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  localparam logic [2:0] KIND_NOP  = 3'd0;
  localparam logic [2:0] KIND_REG  = 3'd1;
  localparam logic [2:0] KIND_LD   = 3'd2;
  localparam logic [2:0] KIND_ST   = 3'd3;
  localparam logic [2:0] KIND_STU  = 3'd4;
  localparam logic [2:0] KIND_HALT = 3'd5;

  typedef struct packed {
    logic [2:0]        kind;
    logic [INUM_W-1:0] inum;
    logic [INUM_W-1:0] cycle;
    logic [15:0]       pc;
    logic [15:0]       inst;
    logic [2:0]        regSel;
    logic [15:0]       regData;
    logic [15:0]       addr;
    logic [15:0]       memData;
  } rec_t;

  rec_t              mem [DEPTH];
  rec_t              newRec;
  rec_t              head;
  logic [PTR_W-1:0]  wrPtr, rdPtr;
  logic [PTR_W:0]    count;
  logic [INUM_W-1:0] inumCnt, cycleCnt;
  logic              haltSeen;
  logic              full, pop, attempt, push, drop;
  logic [2:0]        kind;

  always_comb begin
    kind = KIND_NOP;
    if (wb_reg_write && wb_mem_write)     kind = KIND_STU;
    else if (wb_reg_write && wb_mem_read) kind = KIND_LD;
    else if (wb_reg_write)                kind = KIND_REG;
    else if (wb_halt)                     kind = KIND_HALT;
    else if (wb_mem_write)                kind = KIND_ST;
  end

  assign full     = (count == FULL_CNT);
  assign tr_valid = (count != '0);
  assign wb_stall = full;
  assign pop      = tr_valid && tr_ready;
  assign attempt  = wb_valid && !haltSeen;
  assign push     = attempt && (!full || pop);
  assign drop     = attempt && full && !pop;

  always_comb begin
    newRec.kind    = kind;
    newRec.inum    = inumCnt;
    newRec.cycle   = cycleCnt;
    newRec.pc      = wb_pc;
    newRec.inst    = wb_inst;
    newRec.regSel  = wb_reg_sel;
    newRec.regData = wb_reg_data;
    newRec.addr    = wb_mem_addr;
    newRec.memData = wb_mem_data;
  end

  // Storage needs no reset: outputs are gated by tr_valid.
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= newRec;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      inumCnt  <= '0;
      cycleCnt <= '0;
      haltSeen <= 1'b0;
      halted   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      cycleCnt <= cycleCnt + INUM_W'(1);
      if (push) begin
        wrPtr   <= wrPtr + PTR_W'(1);
        inumCnt <= inumCnt + INUM_W'(1);
        if (kind == KIND_HALT) haltSeen <= 1'b1;
      end
      if (pop) begin
        rdPtr <= rdPtr + PTR_W'(1);
        if (head.kind == KIND_HALT) halted <= 1'b1;
      end
      if (drop) overflow <= 1'b1;
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rdPtr];

  always_comb begin
    tr_kind     = '0;
    tr_inum     = '0;
    tr_cycle    = '0;
    tr_pc       = '0;
    tr_inst     = '0;
    tr_reg      = '0;
    tr_reg_data = '0;
    tr_addr     = '0;
    tr_mem_data = '0;
    if (tr_valid) begin
      tr_kind     = head.kind;
      tr_inum     = head.inum;
      tr_cycle    = head.cycle;
      tr_pc       = head.pc;
      tr_inst     = head.inst;
      tr_reg      = head.regSel;
      tr_reg_data = head.regData;
      tr_addr     = head.addr;
      tr_mem_data = head.memData;
    end
  end

endmodule

// File: tb/tb_retire_trace_unit.sv
// tb/tb_retire_trace_unit.sv - scoreboard bench for retire_trace_unit with a queue-based reference model
module tb_retire_trace_unit;

  localparam int DEPTH = 4;

  logic        clk = 0;
  logic        rst = 0;
  logic        wb_valid = 0;
  logic [15:0] wb_pc = 0, wb_inst = 0, wb_reg_data = 0, wb_mem_addr = 0, wb_mem_data = 0;
  logic        wb_reg_write = 0, wb_mem_read = 0, wb_mem_write = 0, wb_halt = 0;
  logic [2:0]  wb_reg_sel = 0;
  logic        tr_ready = 0;
  logic        wb_stall, tr_valid, halted, overflow;
  logic [2:0]  tr_kind, tr_reg;
  logic [31:0] tr_inum, tr_cycle;
  logic [15:0] tr_pc, tr_inst, tr_reg_data, tr_addr, tr_mem_data;

  retire_trace_unit #(.DEPTH(DEPTH), .INUM_W(32)) dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_inst(wb_inst),
    .wb_reg_write(wb_reg_write), .wb_reg_sel(wb_reg_sel), .wb_reg_data(wb_reg_data),
    .wb_mem_read(wb_mem_read), .wb_mem_write(wb_mem_write), .wb_mem_addr(wb_mem_addr),
    .wb_mem_data(wb_mem_data), .wb_halt(wb_halt), .wb_stall(wb_stall),
    .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_kind(tr_kind), .tr_inum(tr_inum),
    .tr_cycle(tr_cycle), .tr_pc(tr_pc), .tr_inst(tr_inst), .tr_reg(tr_reg),
    .tr_reg_data(tr_reg_data), .tr_addr(tr_addr), .tr_mem_data(tr_mem_data),
    .halted(halted), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  kind;
    logic [31:0] inum, cycle;
    logic [15:0] pc, inst, rdata, addr, mdata;
    logic [2:0]  rsel;
  } rec_t;

  rec_t        expQ[$];
  int          tests = 0, fails = 0;
  int          mCnt = 0;
  logic [31:0] mInum = 0, mCycle = 0;
  bit          mHaltSeen = 0, mOverflow = 0, expHalted = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] classify();
    if (wb_reg_write) return wb_mem_write ? 3'd4 : (wb_mem_read ? 3'd2 : 3'd1);
    if (wb_halt) return 3'd5;
    return wb_mem_write ? 3'd3 : 3'd0;
  endfunction

  // Reference model: occupancy, numbering and cycle stamps from the retirement rules
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      expQ.delete();
      mCnt = 0; mInum = 0; mCycle = 0; mHaltSeen = 0; mOverflow = 0;
    end else begin
      bit   doPop;
      rec_t r;
      doPop = (mCnt > 0) && tr_ready;
      if (wb_valid && !mHaltSeen) begin
        if (mCnt == DEPTH && !doPop) mOverflow = 1;
        else begin
          r.kind = classify(); r.inum = mInum; r.cycle = mCycle;
          r.pc = wb_pc; r.inst = wb_inst; r.rsel = wb_reg_sel; r.rdata = wb_reg_data;
          r.addr = wb_mem_addr; r.mdata = wb_mem_data;
          expQ.push_back(r);
          mInum++; mCnt++;
          if (r.kind == 3'd5) mHaltSeen = 1;
        end
      end
      if (doPop) mCnt--;
      mCycle++;
    end
  end

  // Monitor: compares the presented head against the scoreboard, pops on handshake
  always @(negedge clk) begin
    if (!rst) begin
      check("halted", halted, expHalted);
      check("overflow", overflow, mOverflow);
      check("wb_stall", wb_stall, mCnt == DEPTH);
      check("tr_valid", tr_valid, expQ.size() != 0);
      if (tr_valid && expQ.size() != 0) begin
        check("tr_kind", tr_kind, expQ[0].kind);
        check("tr_inum", tr_inum, expQ[0].inum);
        check("tr_cycle", tr_cycle, expQ[0].cycle);
        check("tr_pc", tr_pc, expQ[0].pc);
        check("tr_inst", tr_inst, expQ[0].inst);
        check("tr_reg", tr_reg, expQ[0].rsel);
        check("tr_reg_data", tr_reg_data, expQ[0].rdata);
        check("tr_addr", tr_addr, expQ[0].addr);
        check("tr_mem_data", tr_mem_data, expQ[0].mdata);
        if (tr_ready) begin
          if (expQ[0].kind == 3'd5) expHalted = 1;
          void'(expQ.pop_front());
        end
      end else if (!tr_valid) begin
        check("idle_zero", {tr_kind, tr_inum, tr_cycle, tr_pc, tr_inst, tr_reg,
                            tr_reg_data, tr_addr, tr_mem_data} == 0, 1);
      end
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic randFields();
    wb_pc = 16'($urandom); wb_inst = 16'($urandom); wb_reg_sel = 3'($urandom);
    wb_reg_data = 16'($urandom); wb_mem_addr = 16'($urandom); wb_mem_data = 16'($urandom);
  endtask

  task automatic retire(input logic rw, input logic mr, input logic mw, input logic h);
    randFields();
    wb_valid = 1; wb_reg_write = rw; wb_mem_read = mr; wb_mem_write = mw; wb_halt = h;
    step();
    wb_valid = 0;
  endtask

  task automatic doReset();
    @(posedge clk); #3;
    wb_valid = 0;
    rst = 1;
    #1;
    check("rst_tr_valid", tr_valid, 0);
    check("rst_wb_stall", wb_stall, 0);
    check("rst_halted", halted, 0);
    check("rst_overflow", overflow, 0);
    check("rst_tr_inum", tr_inum, 0);
    expHalted = 0;
    @(posedge clk); #1;
    rst = 0;
  endtask

  initial begin
    #1 rst = 1;
    step(2);
    rst = 0;
    check("init_tr_valid", tr_valid, 0);

    // single REG retire, then pop
    tr_ready = 0;
    randFields();
    wb_valid = 1; wb_reg_write = 1; wb_reg_sel = 3; wb_reg_data = 16'h1234; wb_pc = 16'h0002;
    wb_mem_read = 0; wb_mem_write = 0; wb_halt = 0;
    step();
    wb_valid = 0;
    check("first_kind", tr_kind, 1);
    check("first_reg_data", tr_reg_data, 16'h1234);
    tr_ready = 1;
    step(2);
    check("first_popped", tr_valid, 0);

    // classification sweep ending in HALT, then ignored retirements
    doReset();
    tr_ready = 1;
    retire(1, 0, 1, 0); retire(1, 1, 0, 0); retire(1, 0, 0, 0);
    retire(0, 0, 1, 0); retire(0, 0, 0, 0); retire(0, 0, 0, 1);
    retire(1, 0, 0, 0); retire(0, 0, 1, 0);
    step(3);
    check("halted_final", halted, 1);

    // fill, drop on overflow, drain
    doReset();
    tr_ready = 0;
    for (int i = 0; i < 4; i++) retire(1, 0, 0, 0);
    check("stall_full", wb_stall, 1);
    retire(0, 0, 1, 0);
    check("overflow_set", overflow, 1);
    step(2);
    tr_ready = 1;
    step(5);

    // simultaneous push and pop at full
    doReset();
    tr_ready = 0;
    for (int i = 0; i < 4; i++) retire(0, 1, 0, 0);
    tr_ready = 1;
    retire(1, 1, 0, 0);
    tr_ready = 0;
    check("full_swap_stall", wb_stall, 1);
    check("full_swap_overflow", overflow, 0);
    tr_ready = 1;
    step(6);

    // reset mid-drain with entries queued
    doReset();
    tr_ready = 0;
    for (int i = 0; i < 4; i++) retire(1, 0, 0, 0);
    tr_ready = 1;
    step();
    doReset();
    tr_ready = 0;
    retire(0, 0, 1, 0);
    check("post_rst_inum", tr_inum, 0);
    tr_ready = 1;
    step(2);

    // back-to-back pushes with continuous draining
    doReset();
    tr_ready = 1;
    for (int i = 0; i < 10; i++) retire(1, 0, 0, 0);
    step(3);

    // randomized traffic with periodic resets
    for (int i = 0; i < 600; i++) begin
      if (i % 75 == 74) doReset();
      randFields();
      wb_valid = ($urandom % 3) != 0;
      wb_reg_write = 1'($urandom); wb_mem_read = 1'($urandom);
      wb_mem_write = 1'($urandom); wb_halt = ($urandom % 20) == 0;
      tr_ready = ($urandom % 4) != 0;
      step();
    end
    wb_valid = 0;
    tr_ready = 1;
    step(8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
